// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Define CLA_SAT_EN to clamp overflowing results to signed saturation.
module cla_pipe_adder #(
    parameter int WIDTH   = 16,
    parameter int GROUP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int NG = WIDTH / GROUP_W;

    // Group propagate/generate of one GROUP_W slice: {P, G}.
    function automatic logic [1:0] group_pg(input logic [GROUP_W-1:0] p,
                                            input logic [GROUP_W-1:0] g);
        logic pp, gg;
        pp = 1'b1;
        gg = 1'b0;
        for (int i = 0; i < GROUP_W; i++) begin
            gg = g[i] | (p[i] & gg);
            pp = pp & p[i];
        end
        return {pp, gg};
    endfunction

    function automatic logic [NG:0] group_carry(input logic [NG-1:0] gp,
                                                input logic [NG-1:0] gg,
                                                input logic          c0);
        logic [NG:0] c;
        logic        term;
        c[0] = c0;
        for (int k = 1; k <= NG; k++) begin
            term = c0;
            for (int m = 0; m < k; m++) term = term & gp[m];
            c[k] = term;
            for (int j = 0; j < k; j++) begin
                term = gg[j];
                for (int m = j + 1; m < k; m++) term = term & gp[m];
                c[k] = c[k] | term;
            end
        end
        return c;
    endfunction

    function automatic logic [GROUP_W:0] bit_carry(input logic [GROUP_W-1:0] p,
                                                   input logic [GROUP_W-1:0] g,
                                                   input logic               c0);
        logic [GROUP_W:0] c;
        logic             term;
        c[0] = c0;
        for (int k = 1; k <= GROUP_W; k++) begin
            term = c0;
            for (int m = 0; m < k; m++) term = term & p[m];
            c[k] = term;
            for (int j = 0; j < k; j++) begin
                term = g[j];
                for (int m = j + 1; m < k; m++) term = term & p[m];
                c[k] = c[k] | term;
            end
        end
        return c;
    endfunction

`ifdef CLA_SAT_EN
    function automatic logic signed [WIDTH-1:0] saturate(input logic signed [WIDTH-1:0] s,
                                                         input logic                    ov,
                                                         input logic                    neg);
        if (!ov) return s;
        return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction
`endif

    logic [WIDTH-1:0] b_eff, p_bit, g_bit;
    logic [NG-1:0]    gp_grp, gg_grp;
    logic             c_eff;

    logic [WIDTH-1:0] p_p1, g_p1;
    logic [NG-1:0]    gp_p1, gg_p1;
    logic             c_p1, amsb_p1, bmsb_p1, vld_p1;

    logic [NG:0]             gcar;
    logic [WIDTH:0]          carry;
    logic signed [WIDTH-1:0] sum_raw, sum_fin;
    logic                    ovf_s;

    logic [WIDTH-1:0] sum_p2;
    logic             cout_p2, ovf_p2, zero_p2, vld_p2;

    logic ld_out, accept;

    assign ld_out   = ~vld_p2 | out_ready;
    assign in_ready = ~rst & (~vld_p1 | ld_out);
    assign accept   = in_valid & in_ready;

    always_comb begin
        b_eff  = sub ? ~b : b;
        c_eff  = cin ^ sub;
        p_bit  = a ^ b_eff;
        g_bit  = a & b_eff;
        gp_grp = '0;
        gg_grp = '0;
        for (int k = 0; k < NG; k++)
            {gp_grp[k], gg_grp[k]} = group_pg(p_bit[k*GROUP_W +: GROUP_W],
                                              g_bit[k*GROUP_W +: GROUP_W]);
    end

    // Stage 1: operand conditioning and bit/group propagate-generate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            p_p1    <= '0;
            g_p1    <= '0;
            gp_p1   <= '0;
            gg_p1   <= '0;
            c_p1    <= 1'b0;
            amsb_p1 <= 1'b0;
            bmsb_p1 <= 1'b0;
        end else begin
            if (in_ready) vld_p1 <= in_valid;
            if (accept) begin
                p_p1    <= p_bit;
                g_p1    <= g_bit;
                gp_p1   <= gp_grp;
                gg_p1   <= gg_grp;
                c_p1    <= c_eff;
                amsb_p1 <= a[WIDTH-1];
                bmsb_p1 <= b_eff[WIDTH-1];
            end
        end
    end

    // Each group's intra-group top carry is superseded by the group-level lookahead carry (same value).
    always_comb begin
        gcar  = group_carry(gp_p1, gg_p1, c_p1);
        carry = '0;
        for (int k = 0; k < NG; k++)
            carry[k*GROUP_W +: GROUP_W+1] = bit_carry(p_p1[k*GROUP_W +: GROUP_W],
                                                      g_p1[k*GROUP_W +: GROUP_W], gcar[k]);
        carry[WIDTH] = gcar[NG];
        sum_raw = p_p1 ^ carry[WIDTH-1:0];
        ovf_s   = (amsb_p1 == bmsb_p1) & (sum_raw[WIDTH-1] != amsb_p1);
`ifdef CLA_SAT_EN
        sum_fin = saturate(sum_raw, ovf_s, amsb_p1);
`else
        sum_fin = sum_raw;
`endif
    end

    // Stage 2: carry resolution, flags, output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2  <= 1'b0;
            sum_p2  <= '0;
            cout_p2 <= 1'b0;
            ovf_p2  <= 1'b0;
            zero_p2 <= 1'b0;
        end else begin
            if (ld_out) vld_p2 <= vld_p1;
            if (ld_out & vld_p1) begin
                sum_p2  <= sum_fin;
                cout_p2 <= carry[WIDTH];
                ovf_p2  <= ovf_s;
                zero_p2 <= ~|sum_fin;
            end
        end
    end

    assign out_valid = vld_p2;
    assign sum       = sum_p2;
    assign cout      = cout_p2;
    assign ovf       = ovf_p2;
    assign zero      = zero_p2;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder (WIDTH=16, GROUP_W=4); honours CLA_SAT_EN.
module tb_cla_pipe_adder;
    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        logic         z;
    } res_t;

    logic         clk, rst, in_valid, in_ready, cin, sub, out_valid, out_ready;
    logic         cout, ovf, zero;
    logic [W-1:0] a, b, sum;

    int   checks = 0;
    int   errors = 0;
    res_t q[$];
    logic held = 1'b0;
    res_t held_res;

    cla_pipe_adder #(.WIDTH(W), .GROUP_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic su);
        int   ux, uy, sx, sy, ur, sr;
        res_t r;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (su) begin
            ur  = ux - uy - int'(ci);
            sr  = sx - sy - int'(ci);
            r.c = (ur >= 0);
        end else begin
            ur  = ux + uy + int'(ci);
            sr  = sx + sy + int'(ci);
            r.c = (ur >= (1 << W));
        end
        r.o = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
        r.s = W'(ur);
`ifdef CLA_SAT_EN
        if (r.o) r.s = (sr < 0) ? W'(1 << (W-1)) : W'((1 << (W-1)) - 1);
`endif
        r.z = (r.s == '0);
        return r;
    endfunction

    always @(negedge clk) begin
        res_t got, exp;
        got = {sum, cout, ovf, zero};
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("hold_vld", out_valid, 1);
                check("hold_data", got, held_res);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("extra_out", out_valid, 0);
                else begin
                    exp = q.pop_front();
                    check("result", got, exp);
                end
            end
            held     = out_valid && !out_ready;
            held_res = got;
            if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));
        end
    end

    task automatic beat(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic su);
        @(posedge clk); #1;
        in_valid = 1'b1; a = x; b = y; cin = ci; sub = su;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        check("accept_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [W+2:0] e);
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        check({tag, "_vld"}, out_valid, 1);
        check(tag, {sum, cout, ovf, zero}, e);
    endtask

    initial begin
        logic [W-1:0] bpa[3], bpb[3];
        logic         acc;
        int           idx;

        rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_vld", out_valid, 0);
        check("rst_data", {sum, cout, ovf, zero}, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("idle_ready", in_ready, 1);

        // Plain add with explicit two-cycle latency
        beat(16'h1234, 16'h4321, 1'b0, 1'b0);
        @(negedge clk);
        check("lat1_vld", out_valid, 0);
        @(negedge clk);
        check("lat2_vld", out_valid, 1);
        check("add_basic", {sum, cout, ovf, zero}, {16'h5555, 1'b0, 1'b0, 1'b0});

        beat(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        expect_out("full_carry", {16'h0000, 1'b1, 1'b0, 1'b1});

        beat(16'h0005, 16'h0007, 1'b0, 1'b1);
        expect_out("sub_borrow", {16'hFFFE, 1'b0, 1'b0, 1'b0});

        beat(16'h8000, 16'h0001, 1'b0, 1'b1);
`ifdef CLA_SAT_EN
        expect_out("sub_ovf", {16'h8000, 1'b1, 1'b1, 1'b0});
`else
        expect_out("sub_ovf", {16'h7FFF, 1'b1, 1'b1, 1'b0});
`endif

        // Back-to-back stream of 8 random beats
        @(posedge clk); #1;
        for (int c = 0; c < 11; c++) begin
            if (c < 8) begin
                in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
                cin = 1'($urandom); sub = 1'($urandom);
            end else in_valid = 1'b0;
            @(negedge clk);
            if (c < 8) check("stream_ready", in_ready, 1);
            check("stream_vld", out_valid, (c >= 2 && c < 10));
            @(posedge clk); #1;
        end

        // Backpressure: 3 beats offered while the consumer stalls for 5 cycles
        for (int i = 0; i < 3; i++) begin
            bpa[i] = W'($urandom);
            bpb[i] = W'($urandom);
        end
        out_ready = 1'b0;
        idx = 0;
        in_valid = 1'b1; a = bpa[0]; b = bpb[0]; cin = 1'b0; sub = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_ready", in_ready, (c < 2));
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 3) begin a = bpa[idx]; b = bpb[idx]; end
                else in_valid = 1'b0;
            end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 20 && (in_valid || q.size() != 0); i++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 3) begin a = bpa[idx]; b = bpb[idx]; end
                else in_valid = 1'b0;
            end
        end
        check("bp_accepts", idx, 3);
        check("bp_drain", q.size(), 0);

        // Random traffic with random consumer stalls
        for (int c = 0; c < 40; c++) begin
            in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
            out_ready = ($urandom_range(3) != 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        check("rand_drain", q.size(), 0);

        // Reset with two beats in flight
        @(posedge clk); #1;
        in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0;
        @(posedge clk); #1;
        a = 16'h3333; b = 16'h4444;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("pre_rst_vld", out_valid, 1);
        rst = 1'b1;
        q.delete();
        #1;
        check("rst_async", {out_valid, sum, cout, ovf, zero}, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_vld", out_valid, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
